// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a byte stream into 32-bit words, writes
// them to instruction memory and releases the core once the checksum verifies.
module imem_loader #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [31:0]           imem_data,
    output logic                  cpu_rst,
    output logic                  cpu_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              words_left_q, words_left_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [31:0]             word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wren_q, wren_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    cpu_en_q, cpu_en_d;
    logic                    accept;

    always_comb begin
        byte_ready = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
        accept     = byte_valid && byte_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            addr_q       <= BASE_ADDR;
            wren_q       <= 1'b0;
            cpu_rst_q    <= 1'b0;
            cpu_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            csum_q       <= csum_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            wren_q       <= wren_d;
            cpu_rst_q    <= cpu_rst_d;
            cpu_en_q     <= cpu_en_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        csum_d       = csum_q;
        word_d       = word_q;
        addr_d       = addr_q;
        wren_d       = 1'b0;

        // Address advances after the write cycle; wren_q never overlaps a start.
        if (wren_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        unique case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d      = S_HEADER;
                    csum_d       = '0;
                    byte_idx_d   = '0;
                    words_left_d = '0;
                    addr_d       = BASE_ADDR;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    words_left_d = byte_data;
                    csum_d       = byte_data;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d     = {word_q[23:0], byte_data};
                    csum_d     = csum_q ^ byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wren_d = 1'b1;
                        if (words_left_q == 8'd0) begin
                            state_d = S_CHECK;
                        end else begin
                            words_left_d = words_left_q - 8'd1;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (byte_data == csum_q) ? S_RUN : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_rst_d = (state_d == S_RUN);
        cpu_en_d  = (state_d == S_RUN);
    end

    always_comb begin
        imem_wren    = wren_q;
        imem_address = addr_q;
        imem_data    = word_q;
        cpu_rst      = cpu_rst_q;
        cpu_enable   = cpu_en_q;
        busy         = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
        done         = (state_q == S_RUN);
        error        = (state_q == S_ERROR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-sequence bench for imem_loader with randomized programs and gaps,
// checked against a stream-level reference model of the expected writes.
module tb_imem_loader;

    localparam int unsigned     AW   = 8;
    localparam logic [AW-1:0]   BASE = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          imem_wren;
    logic [AW-1:0] imem_address;
    logic [31:0]   imem_data;
    logic          cpu_rst;
    logic          cpu_enable;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int failures = 0;
    int wren_seen = 0;
    logic [31:0] prog[$];

    imem_loader #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_wren   (imem_wren),
        .imem_address(imem_address),
        .imem_data   (imem_data),
        .cpu_rst     (cpu_rst),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_wren) wren_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        waited = 0;
        while (!byte_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_timeout", 32'(waited < 100), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Streams prog[] as header/data/check; inject >= 0 pulses start before that data byte.
    task automatic run_load(input bit corrupt, input int maxgap, input int inject);
        int            n;
        int            k;
        int            base_wren;
        logic [7:0]    h;
        logic [7:0]    cs;
        logic [7:0]    b;
        logic [31:0]   w;
        logic [AW-1:0] ea;
        n = prog.size();
        base_wren = wren_seen;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(byte_ready), 32'd1);
        chk("start_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("start_cpu_en", 32'(cpu_enable), 32'd0);
        chk("start_done", 32'(done), 32'd0);
        h  = 8'(n - 1);
        cs = h;
        send_byte(h, $urandom_range(0, maxgap));
        k = 0;
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int j = 0; j < 4; j++) begin
                b = w[31 - 8*j -: 8];
                if (k == inject) begin
                    pulse_start();
                    chk("inject_busy", 32'(busy), 32'd1);
                end
                cs = cs ^ b;
                send_byte(b, $urandom_range(0, maxgap));
                k++;
                if (j == 3) begin
                    ea = BASE + AW'(i);
                    chk("wr_en", 32'(imem_wren), 32'd1);
                    chk("wr_addr", 32'(imem_address), 32'(ea));
                    chk("wr_data", imem_data, w);
                end
            end
        end
        chk("pre_release_cpu_rst", 32'(cpu_rst), 32'd0);
        send_byte(corrupt ? (cs ^ 8'h01) : cs, $urandom_range(0, maxgap));
        chk("end_done", 32'(done), 32'(!corrupt));
        chk("end_error", 32'(error), 32'(corrupt));
        chk("end_cpu_rst", 32'(cpu_rst), 32'(!corrupt));
        chk("end_cpu_en", 32'(cpu_enable), 32'(!corrupt));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(byte_ready), 32'd0);
        chk("wren_count", 32'(wren_seen - base_wren), 32'(n));
        ea = BASE + AW'(n);
        chk("end_addr", 32'(imem_address), 32'(ea));
    endtask

    initial begin
        int base_wren;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_wren", 32'(imem_wren), 32'd0);
        chk("rst_addr", 32'(imem_address), 32'(BASE));
        chk("rst_data", imem_data, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("rst_cpu_en", 32'(cpu_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single word from the worked example (checksum 2D)
        prog = '{32'h2008_0005};
        run_load(1'b0, 0, -1);

        // three random words with 0..3 cycle gaps; start issued from RUN
        prog = '{$urandom(), $urandom(), $urandom()};
        run_load(1'b0, 3, -1);

        // bad checksum, then retry from ERROR
        prog = '{32'h2008_0005};
        run_load(1'b1, 0, -1);
        run_load(1'b0, 1, -1);

        // start pulsed mid-word in DATA must be ignored
        prog = '{$urandom(), $urandom()};
        run_load(1'b0, 1, 2);

        // async reset after 2 of 4 data bytes
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("mid_rst_addr", 32'(imem_address), 32'(BASE));
        chk("mid_rst_data", imem_data, 32'd0);
        base_wren = wren_seen;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_wren", 32'(wren_seen - base_wren), 32'd0);
        prog = '{$urandom()};
        run_load(1'b0, 2, -1);

        // full 256-word load; address wraps after the last write
        prog = {};
        for (int i = 0; i < 256; i++) prog.push_back($urandom());
        run_load(1'b0, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
